// File: rtl/bit_demux_reg32.sv
// bit_demux_reg32: serial-to-parallel 32-bit collector with direct bit writes.
// Optional macro BIT_DEMUX_LSB_FIRST_EN selects LSB-first collection order.
module bit_demux_reg32 (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        wr_en,
  input  logic [4:0]  wr_sel,
  input  logic        wr_bit,
  output logic [31:0] result,
  output logic [4:0]  index,
  output logic        busy,
  output logic        data_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

`ifdef BIT_DEMUX_LSB_FIRST_EN
  localparam logic [4:0] START_POS = 5'd0;
  localparam logic [4:0] FINAL_POS = 5'd31;
`else
  localparam logic [4:0] START_POS = 5'd31;
  localparam logic [4:0] FINAL_POS = 5'd0;
`endif

  state_t     state;
  logic [4:0] index_nxt;

  // next position in collection order
  always_comb begin
`ifdef BIT_DEMUX_LSB_FIRST_EN
    index_nxt = index + 5'd1;
`else
    index_nxt = index - 5'd1;
`endif
  end

  // state, collected word, index and registered status decodes
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      result     <= 32'h0;
      index      <= START_POS;
      busy       <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= COLLECT;
            result     <= 32'h0;
            index      <= START_POS;
            busy       <= 1'b1;
            data_ready <= 1'b0;
          end else if (wr_en) begin
            result[wr_sel] <= wr_bit;
          end
        end
        COLLECT: begin
          if (start) begin
            result <= 32'h0;
            index  <= START_POS;
          end else if (bit_valid) begin
            result[index] <= bit_in;
            if (index == FINAL_POS) begin
              state      <= DONE;
              index      <= START_POS;
              busy       <= 1'b0;
              data_ready <= 1'b1;
            end else begin
              index <= index_nxt;
            end
          end
        end
        default: begin
          state      <= IDLE;
          result     <= 32'h0;
          index      <= START_POS;
          busy       <= 1'b0;
          data_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_demux_reg32.sv
// tb_bit_demux_reg32: directed stimulus, abstract bit-count model,
// per-cycle compare plus literal expectations. Honours BIT_DEMUX_LSB_FIRST_EN.
module tb_bit_demux_reg32;

  logic        clock;
  logic        reset;
  logic        start;
  logic        bit_in;
  logic        bit_valid;
  logic        wr_en;
  logic [4:0]  wr_sel;
  logic        wr_bit;
  logic [31:0] result;
  logic [4:0]  index;
  logic        busy;
  logic        data_ready;

  int tests;
  int fails;

  bit_demux_reg32 dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_bit     (wr_bit),
    .result     (result),
    .index      (index),
    .busy       (busy),
    .data_ready (data_ready)
  );

`ifdef BIT_DEMUX_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Bit position reached after n captured bits.
  function automatic logic [4:0] idx_after(input int n);
    if (LSB) return 5'(n);
    return 5'(31 - n);
  endfunction

  // Model: mode 0=idle 1=collecting 2=done, word, bits captured.
  int          m_mode;
  int          m_cnt;
  logic [31:0] m_word;
  bit          m_live;

  always @(posedge clock) begin
    if (reset) begin
      m_mode = 0;
      m_word = 32'h0;
      m_cnt  = 0;
      m_live = 1'b1;
    end else if (m_mode != 1) begin
      if (start) begin
        m_mode = 1;
        m_word = 32'h0;
        m_cnt  = 0;
      end else if (wr_en) begin
        m_word[wr_sel] = wr_bit;
      end
    end else begin
      if (start) begin
        m_word = 32'h0;
        m_cnt  = 0;
      end else if (bit_valid) begin
        m_word[idx_after(m_cnt)] = bit_in;
        m_cnt = m_cnt + 1;
        if (m_cnt == 32) begin
          m_mode = 2;
          m_cnt  = 0;
        end
      end
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clock) begin
    if (m_live) begin
      check("m_result", result, m_word);
      check("m_index", 32'(index), 32'(idx_after(m_cnt)));
      check("m_busy", 32'(busy), 32'(m_mode == 1));
      check("m_ready", 32'(data_ready), 32'(m_mode == 2));
    end
  end

  task automatic cyc(input logic st, input logic bv,
                     input logic bi, input logic we,
                     input logic [4:0] ws, input logic wb);
    start     = st;
    bit_valid = bv;
    bit_in    = bi;
    wr_en     = we;
    wr_sel    = ws;
    wr_bit    = wb;
    @(negedge clock);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_cyc();
    reset = 1'b0;
  endtask

  // Start then feed w in collection order; returns busy-high count.
  task automatic feed(input logic [31:0] w, input bit gaps,
                      output int bcnt);
    logic [4:0] p;
    bcnt = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    if (busy) bcnt++;
    for (int k = 0; k < 32; k++) begin
      p = idx_after(k);
      cyc(1'b0, 1'b1, w[p], 1'b0, 5'd0, 1'b0);
      if (busy) bcnt++;
      if (gaps) begin
        idle_cyc();
        check("gap_index", 32'(index), 32'(idx_after(k + 1)));
      end
    end
  endtask

  int bc;

  initial begin
    tests = 0;
    fails = 0;
    m_live = 1'b0;
    m_mode = 0;
    m_cnt = 0;
    m_word = 32'h0;
    reset = 1'b0;
    start = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    wr_en = 1'b0;
    wr_sel = 5'd0;
    wr_bit = 1'b0;
    @(negedge clock);
    do_reset();
    check("rst_result", result, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(data_ready), 32'h0);
    check("rst_index", 32'(index), LSB ? 32'd0 : 32'd31);

    // continuous stream
    feed(32'hA5A5_0F0F, 1'b0, bc);
    check("busy_cycles", 32'(bc), 32'd32);
    check("ready_on_last", 32'(data_ready), 32'h1);
    check("stream_word", result, 32'hA5A5_0F0F);

    // DONE holds; bit_valid ignored there
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    idle_cyc();
    check("done_hold", result, 32'hA5A5_0F0F);
    check("done_ready", 32'(data_ready), 32'h1);

    // direct write in DONE
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    check("done_wr", result, 32'hA5A5_0F0E);

    // stream with gaps
    feed(32'hA5A5_0F0F, 1'b1, bc);
    check("gap_word", result, 32'hA5A5_0F0F);

    // restart mid-collection then zeros
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 10; k++)
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    check("restart_clr", result, 32'h0);
    check("restart_idx", 32'(index), LSB ? 32'd0 : 32'd31);
    for (int k = 0; k < 32; k++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    check("zeros_word", result, 32'h0);
    check("zeros_ready", 32'(data_ready), 32'h1);

    // direct write in IDLE
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1);
    check("idle_wr", result, 32'h0000_0080);
    check("idle_wr_busy", 32'(busy), 32'h0);

    // start beats wr_en
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1);
    check("start_wins", result, 32'h0);

    // wr_en ignored while collecting
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
    check("collect_wr", result, 32'h0);
    check("collect_busy", 32'(busy), 32'h1);

    // reset after bit 16
    for (int k = 0; k < 16; k++)
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1);
    reset = 1'b0;
    check("mid_rst_result", result, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ready", 32'(data_ready), 32'h0);
    check("mid_rst_index", 32'(index), LSB ? 32'd0 : 32'd31);

    // first bit 1 then 31 zeros, index tracked each step
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      check("step_index", 32'(index), 32'(idx_after(k)));
      cyc(1'b0, 1'b1, k == 0, 1'b0, 5'd0, 1'b0);
    end
    check("first_one", result,
          LSB ? 32'h0000_0001 : 32'h8000_0000);
    check("first_one_ready", 32'(data_ready), 32'h1);

    idle_cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_demux_reg32.md
BIT_DEMUX_REG32 -- requirements
Module: bit_demux_reg32

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 32 bits with a 5-bit index.
REQ-002 clock  input  1  rising-edge clock for all state; the block SHALL use this single clock only.
REQ-003 reset  input  1  synchronous, active-high reset; the block SHALL sample it only on the rising edge of clock.
REQ-004 start  input  1  begin a new 32-bit serial collection.
REQ-005 bit_in  input  1  serial data bit.
REQ-006 bit_valid  input  1  bit_in is valid this cycle.
REQ-007 wr_en  input  1  direct single-bit write request.
REQ-008 wr_sel  input  5  target bit index for a direct write.
REQ-009 wr_bit  input  1  value for a direct write.
REQ-010 result  output  32  registered collected word.
REQ-011 index  output  5  next bit position to be written in COLLECT.
REQ-012 busy  output  1  high in COLLECT.
REQ-013 data_ready  output  1  high in DONE.

Function
REQ-014 The state machine SHALL have exactly three states: IDLE, COLLECT and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL move to COLLECT on the next edge, clear result to 32'h0 and load index with the start position (REQ-027).
REQ-016 In COLLECT, start=1 SHALL restart: clear result, reload index, stay in COLLECT, and ignore bit_valid that cycle.
REQ-017 In COLLECT, bit_valid=1 with start=0 SHALL write bit_in to result[index] on that edge; other result bits SHALL be unchanged.
REQ-018 After each captured bit, index SHALL step one position in collection order (REQ-027); bit_valid=0 SHALL hold all state.
REQ-019 Capturing the final position SHALL move to DONE on the same edge; index SHALL then hold at the start position.
REQ-020 busy SHALL be high only in COLLECT; data_ready SHALL be high only in DONE. Both SHALL be registered state decodes with no combinational path from inputs.
REQ-021 Capture latency SHALL be one cycle: a bit written on edge N SHALL be visible on result after edge N.
REQ-022 In IDLE or DONE, wr_en=1 with start=0 SHALL write wr_bit to result[wr_sel] without changing the state.
REQ-023 wr_en SHALL be ignored in COLLECT; bit_valid SHALL be ignored in IDLE and DONE.
REQ-024 If start and wr_en are both high, start SHALL win and the write SHALL be discarded.
REQ-025 DONE SHALL hold result and data_ready until start or reset; there SHALL be no automatic return to IDLE.

Reset
REQ-026 On reset=1 at an edge, the block SHALL go to IDLE with result=32'h0, busy=0 and data_ready=0. index SHALL be set to the start position. Reset SHALL override start, bit_valid and wr_en, including mid-COLLECT.

Configuration
REQ-027 The macro BIT_DEMUX_LSB_FIRST_EN SHALL select the collection order:
- Not defined: MSB-first; start position 31; index decrements; final position 0.
- Defined: LSB-first; start position 0; index increments; final position 31.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-028 Default build, reset, then start. Feed 32 valid bits of 32'hA5A5_0F0F MSB-first with no gaps:
- busy high for 32 cycles;
- data_ready rises on the edge of the 32nd bit;
- result=32'hA5A5_0F0F.
REQ-029 Same stream with bit_valid low every other cycle (64 cycles total): result=32'hA5A5_0F0F, and index holds on idle cycles.
REQ-030 Start, then 10 valid bits of 1, then start again, then 32 zeros: result=32'h0 and data_ready high afterwards.
REQ-031 In IDLE, wr_en with wr_sel=5'd7, wr_bit=1 -> result=32'h0000_0080. wr_en during COLLECT -> result unchanged.
REQ-032 Assert reset after bit 16 of a collection: next cycle shows IDLE, result=0, busy=0, data_ready=0.
REQ-033 LSB_FIRST build: feed bits 1,0,0,...,0 (32 bits) -> result=32'h0000_0001, and index steps 0->31.
